// File: rtl/multi_lane_multiplier_if.sv
// Job/result bus of the multi-lane FP32 multiplier dispatcher.
// The master drives job requests and operand pairs; the slave returns results.
interface multi_lane_multiplier_if #(
   parameter int unsigned LANE_W = 2
) ();
   logic              ready;
   logic [LANE_W-1:0] n_ops;
   logic [31:0]       op1;
   logic [31:0]       op2;
   logic              busy;
   logic [31:0]       res;
   logic              res_valid;
   logic [LANE_W-1:0] res_lane;
   logic              done;
   logic              err;

   modport master (
      output ready, n_ops, op1, op2,
      input  busy, res, res_valid, res_lane, done, err
   );

   modport slave (
      input  ready, n_ops, op1, op2,
      output busy, res, res_valid, res_lane, done, err
   );
endinterface

// File: rtl/multi_lane_multiplier.sv
// FP32 multiply dispatcher: loads up to LANES operand pairs, runs one core per lane,
// waits for all active lanes (or a timeout) and streams the results out in lane order.

// Two-stage FP32 multiplier core: round-to-nearest-even, subnormals flushed to zero.
module fp32_mul_core (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ready_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   output logic [31:0] res_o,
   output logic        done_o
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {KNorm, KZero, KInf, KNan} kind_e;

   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [23:0]        sig_a, sig_b;
   kind_e              kind_d, s1_kind_q;
   logic               s1_valid_q, s1_sign_q;
   logic signed [9:0]  s1_exp_q, exp_n, exp_f;
   logic [47:0]        s1_prod_q;
   logic [22:0]        mant;
   logic               guard, sticky, round_up;
   logic [23:0]        mant_sum;
   logic [31:0]        res_d, res_q;
   logic               done_q;

   always_comb begin
      a_zero = (op_a_i[30:23] == 8'd0);
      b_zero = (op_b_i[30:23] == 8'd0);
      a_inf  = (op_a_i[30:23] == 8'hFF) && (op_a_i[22:0] == 23'd0);
      b_inf  = (op_b_i[30:23] == 8'hFF) && (op_b_i[22:0] == 23'd0);
      a_nan  = (op_a_i[30:23] == 8'hFF) && (op_a_i[22:0] != 23'd0);
      b_nan  = (op_b_i[30:23] == 8'hFF) && (op_b_i[22:0] != 23'd0);
      sig_a  = {1'b1, op_a_i[22:0]};
      sig_b  = {1'b1, op_b_i[22:0]};
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         kind_d = KNan;
      end else if (a_inf || b_inf) begin
         kind_d = KInf;
      end else if (a_zero || b_zero) begin
         kind_d = KZero;
      end else begin
         kind_d = KNorm;
      end
   end

   // Normalise the 48-bit significand product and round to nearest, ties to even.
   always_comb begin
      if (s1_prod_q[47]) begin
         mant   = s1_prod_q[46:24];
         guard  = s1_prod_q[23];
         sticky = |s1_prod_q[22:0];
         exp_n  = s1_exp_q + 10'sd1;
      end else begin
         mant   = s1_prod_q[45:23];
         guard  = s1_prod_q[22];
         sticky = |s1_prod_q[21:0];
         exp_n  = s1_exp_q;
      end
      round_up = guard & (sticky | mant[0]);
      mant_sum = {1'b0, mant} + {23'd0, round_up};
      exp_f    = exp_n + (mant_sum[23] ? 10'sd1 : 10'sd0);
      res_d    = QNAN;
      unique case (s1_kind_q)
         KNan:  res_d = QNAN;
         KInf:  res_d = {s1_sign_q, 8'hFF, 23'd0};
         KZero: res_d = {s1_sign_q, 31'd0};
         KNorm: begin
            if (exp_f >= 10'sd255) begin
               res_d = {s1_sign_q, 8'hFF, 23'd0};
            end else if (exp_f <= 10'sd0) begin
               res_d = {s1_sign_q, 31'd0};
            end else begin
               res_d = {s1_sign_q, exp_f[7:0], mant_sum[22:0]};
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_prod_q  <= '0;
         s1_kind_q  <= KZero;
         res_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         s1_valid_q <= ready_i;
         if (ready_i) begin
            s1_sign_q <= op_a_i[31] ^ op_b_i[31];
            s1_exp_q  <= $signed({2'b00, op_a_i[30:23]}) + $signed({2'b00, op_b_i[30:23]})
                         - 10'sd127;
            s1_prod_q <= 48'(sig_a) * 48'(sig_b);
            s1_kind_q <= kind_d;
         end
         done_q <= s1_valid_q;
         if (s1_valid_q) begin
            res_q <= res_d;
         end
      end
   end

   assign res_o  = res_q;
   assign done_o = done_q;
endmodule

module multi_lane_multiplier #(
   parameter int unsigned LANE_W  = 2,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TO_W    = 16
) (
   input logic                    clk,
   input logic                    rst,
   multi_lane_multiplier_if.slave bus
);
   localparam int unsigned     LANES   = 2 ** LANE_W;
   localparam logic [31:0]     QNAN    = 32'h7FC0_0000;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StRet} state_e;

   state_e                  state_q;
   logic [LANE_W-1:0]       n_q, idx_q;
   logic [TO_W-1:0]         cnt_q;
   logic [LANES-1:0][31:0]  a_q, b_q;
   logic [LANES-1:0]        start_q, armed_q, flag_q;
   logic                    err_q;
   logic [31:0]             res_q;
   logic                    res_valid_q, done_q, err_out_q;
   logic [LANE_W-1:0]       res_lane_q;

   logic [LANES-1:0]        core_done, active, seen;
   logic [LANES-1:0][31:0]  core_res;
   logic                    all_done;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic        lane_done;
      logic [31:0] lane_res;

      fp32_mul_core u_core (
         .clk_i   (clk),
         .rst_i   (rst),
         .ready_i (start_q[k]),
         .op_a_i  (a_q[k]),
         .op_b_i  (b_q[k]),
         .res_o   (lane_res),
         .done_o  (lane_done)
      );

      assign core_done[k] = lane_done;
      assign core_res[k]  = lane_res;
   end

   // A core's done only counts once the lane has been armed by its own start pulse.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         active[k] = (k <= int'(n_q));
      end
      seen     = flag_q | (armed_q & core_done);
      all_done = &(seen | ~active);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         n_q         <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         start_q     <= '0;
         armed_q     <= '0;
         flag_q      <= '0;
         err_q       <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         res_lane_q  <= '0;
         done_q      <= 1'b0;
         err_out_q   <= 1'b0;
      end else begin
         start_q     <= '0;
         armed_q     <= armed_q | start_q;
         flag_q      <= seen;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_out_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.ready) begin
                  a_q[0]     <= bus.op1;
                  b_q[0]     <= bus.op2;
                  start_q[0] <= 1'b1;
                  armed_q    <= '0;
                  flag_q     <= '0;
                  err_q      <= 1'b0;
                  n_q        <= bus.n_ops;
                  idx_q      <= LANE_W'(1);
                  cnt_q      <= '0;
                  state_q    <= (bus.n_ops == '0) ? StWait : StLoad;
               end
            end
            StLoad: begin
               a_q[idx_q]     <= bus.op1;
               b_q[idx_q]     <= bus.op2;
               start_q[idx_q] <= 1'b1;
               idx_q          <= idx_q + LANE_W'(1);
               if (idx_q == n_q) begin
                  cnt_q   <= '0;
                  state_q <= StWait;
               end
            end
            StWait: begin
               // All-done takes priority over a timeout expiring in the same cycle.
               if (all_done) begin
                  idx_q   <= '0;
                  state_q <= StRet;
               end else if (cnt_q == TO_LAST) begin
                  err_q   <= 1'b1;
                  idx_q   <= '0;
                  state_q <= StRet;
               end else begin
                  cnt_q <= cnt_q + TO_W'(1);
               end
            end
            StRet: begin
               res_valid_q <= 1'b1;
               res_lane_q  <= idx_q;
               res_q       <= flag_q[idx_q] ? core_res[idx_q] : QNAN;
               idx_q       <= idx_q + LANE_W'(1);
               if (idx_q == n_q) begin
                  done_q    <= 1'b1;
                  err_out_q <= err_q;
                  state_q   <= StIdle;
               end
            end
         endcase
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.res       = res_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_lane  = res_lane_q;
   assign bus.done      = done_q;
   assign bus.err       = err_out_q;
endmodule

// File: tb/tb_multi_lane_multiplier.sv
// Self-checking bench for multi_lane_multiplier: directed test-plan jobs, timeout cases
// and random jobs checked against a real-arithmetic FP32 product model.
module tb_multi_lane_multiplier;
   localparam int unsigned LANE_W  = 2;
   localparam int unsigned TIMEOUT = 64;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   multi_lane_multiplier_if #(.LANE_W(LANE_W)) bus ();

   multi_lane_multiplier #(
      .LANE_W  (LANE_W),
      .TIMEOUT (TIMEOUT),
      .TO_W    (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] pa[4], pb[4], exp_res[4];
   logic [31:0] g_res[$];
   logic [1:0]  g_lane[$];
   bit          g_done[$], g_err[$];
   int          first_lat;

   // Operands carry 12-bit significands so every product is exact in FP32.
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) d = {f[31], 63'd0};
      else d = {f[31], 11'(f[30:23] + 896), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 896), d[51:29]};
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) * f2r(b));
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [10:0] m;
      logic [7:0]  e;
      logic        s;
      m = 11'($urandom_range(0, 2047));
      e = 8'($urandom_range(100, 154));
      s = 1'($urandom_range(0, 1));
      return {s, e, m, 12'd0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_job(input int n);
      for (int k = 0; k <= n; k++) exp_res[k] = ref_mul(pa[k], pb[k]);
   endtask

   // Called #1 after a posedge; returns #1 after the edge that captures lane n.
   task automatic start_job(input int n, input bit hold);
      bus.ready = 1'b1;
      bus.n_ops = 2'(n);
      bus.op1   = pa[0];
      bus.op2   = pb[0];
      sync();
      for (int k = 1; k <= n; k++) begin
         bus.op1 = pa[k];
         bus.op2 = pb[k];
         sync();
      end
      if (!hold) bus.ready = 1'b0;
      bus.op1 = $urandom();
      bus.op2 = $urandom();
   endtask

   // elapsed = edges already seen since the start edge; returns at the done negedge.
   task automatic collect(input bit hold, input int elapsed);
      int e;
      bit fin;
      e = elapsed;
      fin = 1'b0;
      first_lat = -1;
      g_res.delete(); g_lane.delete(); g_done.delete(); g_err.delete();
      while (!fin && e < elapsed + 200) begin
         @(negedge clk);
         if (bus.res_valid) begin
            if (first_lat < 0) first_lat = e;
            g_res.push_back(bus.res);
            g_lane.push_back(bus.res_lane);
            g_done.push_back(bus.done);
            g_err.push_back(bus.err);
            if (bus.done) begin
               fin = 1'b1;
               if (hold) bus.ready = 1'b0;
            end
         end
         if (!fin) begin
            @(posedge clk);
            e++;
         end
      end
      check("done seen", 32'(fin), 32'd1);
   endtask

   task automatic check_job(input string tag, input int n, input bit exp_err);
      check($sformatf("%s count", tag), 32'(g_res.size()), 32'(n + 1));
      for (int k = 0; k <= n && k < g_res.size(); k++) begin
         check($sformatf("%s res%0d", tag, k), g_res[k], exp_res[k]);
         check($sformatf("%s lane%0d", tag, k), 32'(g_lane[k]), 32'(k));
         check($sformatf("%s done%0d", tag, k), 32'(g_done[k]), 32'(k == n));
         check($sformatf("%s err%0d", tag, k), 32'(g_err[k]), 32'((k == n) && exp_err));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " busy"}, 32'(bus.busy), 32'd0);
      check({tag, " res"}, bus.res, 32'd0);
      check({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
      check({tag, " res_lane"}, 32'(bus.res_lane), 32'd0);
      check({tag, " done"}, 32'(bus.done), 32'd0);
      check({tag, " err"}, 32'(bus.err), 32'd0);
   endtask

   task automatic set_plan_pairs();
      pa[0] = 32'h3FC0_0000; pb[0] = 32'h3FC0_0000;
      pa[1] = 32'hC000_0000; pb[1] = 32'h3F00_0000;
      pa[2] = 32'h3F80_0000; pb[2] = 32'h3F80_0000;
      pa[3] = 32'h4000_0000; pb[3] = 32'h4040_0000;
   endtask

   initial begin
      int n;
      vectors     = 0;
      miscompares = 0;
      rst       = 1'b1;
      bus.ready = 1'b0;
      bus.n_ops = '0;
      bus.op1   = '0;
      bus.op2   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      sync();
      rst = 1'b0;
      sync();

      // Single-pair job
      pa[0] = 32'h4000_0000; pb[0] = 32'h4040_0000;
      exp_res[0] = 32'h40C0_0000;
      start_job(0, 1'b0);
      collect(1'b0, 0);
      check_job("n0", 0, 1'b0);
      check("n0 busy", 32'(bus.busy), 32'd0);
      sync();
      @(negedge clk);
      check("n0 hold res", bus.res, 32'h40C0_0000);
      check("n0 hold valid", 32'(bus.res_valid), 32'd0);
      check("n0 hold done", 32'(bus.done), 32'd0);
      sync();

      // Full four-lane job
      set_plan_pairs();
      exp_res[0] = 32'h4010_0000; exp_res[1] = 32'hBF80_0000;
      exp_res[2] = 32'h3F80_0000; exp_res[3] = 32'h40C0_0000;
      start_job(3, 1'b0);
      collect(1'b0, 3);
      check_job("full", 3, 1'b0);
      sync();

      // ready held through LOAD, WAIT and RET
      for (int k = 0; k < 4; k++) begin pa[k] = rnd_op(); pb[k] = rnd_op(); end
      expect_job(3);
      start_job(3, 1'b1);
      collect(1'b1, 3);
      check_job("hold", 3, 1'b0);
      sync();
      @(negedge clk);
      check("hold busy", 32'(bus.busy), 32'd0);
      check("hold no extra", 32'(bus.res_valid), 32'd0);
      sync();

      // Lane 2 never finishes: timeout after TIMEOUT wait cycles
      set_plan_pairs();
      expect_job(3);
      exp_res[2] = QNAN;
      force dut.g_lane[2].lane_done = 1'b0;
      start_job(3, 1'b0);
      collect(1'b0, 3);
      release dut.g_lane[2].lane_done;
      check_job("tmo", 3, 1'b1);
      check("tmo latency", 32'(first_lat), 32'(3 + TIMEOUT + 1));
      sync();

      // Lane 2 done lands in the very last wait cycle
      set_plan_pairs();
      expect_job(3);
      force dut.g_lane[2].lane_done = 1'b0;
      start_job(3, 1'b0);
      repeat (TIMEOUT - 1) sync();
      force dut.g_lane[2].lane_done = 1'b1;
      sync();
      release dut.g_lane[2].lane_done;
      collect(1'b0, 3 + TIMEOUT);
      check_job("edge", 3, 1'b0);
      check("edge latency", 32'(first_lat), 32'(3 + TIMEOUT + 1));
      sync();

      // Asynchronous reset in the middle of WAIT
      force dut.g_lane[2].lane_done = 1'b0;
      set_plan_pairs();
      start_job(3, 1'b0);
      repeat (10) sync();
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      release dut.g_lane[2].lane_done;
      sync();
      rst = 1'b0;
      sync();
      pa[0] = 32'h3F80_0000; pb[0] = 32'h4000_0000;
      pa[1] = 32'h4000_0000; pb[1] = 32'h4000_0000;
      exp_res[0] = 32'h4000_0000; exp_res[1] = 32'h4080_0000;
      start_job(1, 1'b0);
      collect(1'b0, 1);
      check_job("post", 1, 1'b0);
      sync();

      // Random jobs against the reference model
      for (int j = 0; j < 12; j++) begin
         n = $urandom_range(0, 3);
         for (int k = 0; k < 4; k++) begin pa[k] = rnd_op(); pb[k] = rnd_op(); end
         expect_job(n);
         start_job(n, 1'b0);
         collect(1'b0, n);
         check_job($sformatf("rnd%0d", j), n, 1'b0);
         repeat ($urandom_range(1, 3)) sync();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/multi_lane_multiplier.md
Name: multi_lane_multiplier

Overview:
- Parametrised dispatcher for single-precision multiplication. It owns LANES instances of the team's single-precision multiplier core.
- Accepts a job of 1..LANES operand pairs streamed on consecutive cycles. It starts each lane one cycle after capturing that lane's pair, waits for every active lane to finish or time out, then streams the results out in lane order.
- Generalises the fixed two-unit dual multiplier to N lanes, variable job size, timeout/error reporting, and a per-result valid strobe.

Parameters:
- LANE_W, 2, log2 of lane count; LANES = 2**LANE_W (localparam).
- TIMEOUT, 64, maximum WAIT cycles before the job is aborted; must be ≥1.
- TO_W, 16, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset; also drives every lane core's reset.
- ready  in  1  job start request; sampled only in IDLE.
- n_ops  in  LANE_W  number of pairs minus 1; sampled with ready.
- op1  in  32  operand A; lane k's value is captured k cycles after the start cycle.
- op2  in  32  operand B; captured with op1.
- busy  out  1  high in every state except IDLE.
- res  out  32  result word, registered.
- res_valid  out  1  high for one cycle per emitted result.
- res_lane  out  LANE_W  lane index of the current res.
- done  out  1  one-cycle pulse coincident with the last result of a job.
- err  out  1  high together with done if any lane timed out.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- On reset:
  - state = IDLE.
  - busy, res_valid, done, err = 0; res = 0; res_lane = 0.
  - All lane operand registers, start pulses, done flags and counters = 0.
- Reset mid-job aborts the job with no output. The next job starts fresh.
- States: IDLE, LOAD, WAIT, RET.
- IDLE:
  - If ready=1 at edge T: capture op1/op2 into lane 0, latch n_ops as N, clear all done flags and err, go to LOAD, or straight to WAIT if N=0.
  - ready=0: stay in IDLE.
- LOAD:
  - At edge T+k (k=1..N), capture op1/op2 into lane k.
  - After capturing lane N, go to WAIT.
  - ready is ignored.
- Lane start:
  - Lane k's start pulse (core ready) is high for exactly one cycle, the cycle after its capture edge.
  - Lane k's operand registers stay stable until the next job's capture of lane k.
  - Lanes above N are never started.
- Done flags:
  - Lane k's sticky flag sets on any cycle its core done=1, but only from the cycle after its start pulse onward. Earlier or stale done is ignored.
  - Flags clear only on a new job or reset.
- WAIT:
  - The timeout counter starts at 0 on WAIT entry and increments every WAIT cycle.
  - When all flags 0..N are set (same-cycle done included), go to RET.
  - If the counter reaches TIMEOUT first: set err=1, go to RET.
  - If all-done and timeout occur in the same cycle, all-done wins and err=0.
- RET:
  - Emits lanes 0..N on consecutive cycles starting the cycle after RET entry. Each cycle: res_valid=1, res_lane=k, res = lane k's core res.
  - A lane whose flag is unset (timeout case) emits 0x7FC00000 (quiet NaN).
  - done=1 and err (as latched) on the lane N cycle, then IDLE.
- Output hold: res and res_lane hold their last values after a job; res_valid, done and err are 0 outside their qualifying cycles.
- Minimum latency from ready edge to first res_valid: N + 1 (start) + core latency + 2 cycles.
- No arithmetic in this block: results pass through unmodified.

Test Plan:
- N=0, op1=0x40000000, op2=0x40400000 -> one res_valid: res=0x40C00000, res_lane=0, done=1, err=0, then busy=0.
- Full job, LANES=4, N=3:
  - pairs (0x3FC00000,0x3FC00000), (0xC0000000,0x3F000000), (0x3F800000,0x3F800000), (0x40000000,0x40400000)
  - -> res sequence 0x40100000, 0xBF800000, 0x3F800000, 0x40C00000 on 4 consecutive cycles, res_lane 0..3, done only with lane 3.
- ready held high throughout a job and asserted during RET -> no second capture; a new job starts only from IDLE.
- Lane 2 done forced low (N=3, TIMEOUT=64) -> after 64 WAIT cycles: lane 2 emits 0x7FC00000, others correct, done=1 with err=1.
- rst pulsed during WAIT -> all outputs 0 immediately (asynchronous). A following N=1 job (0x3F800000×0x40000000, 0x40000000×0x40000000) yields 0x40000000, 0x40800000, err=0.
- Core done asserted in the same cycle as timeout expiry -> err=0, correct result emitted.
